core_bus_responder: RTL and testbench

- Target side of the core's instruction and data request interfaces. These are the signals the pipeline hazard logic watches: instr_read/instr_ready and data_read/data_write/data_ready.
- Arbitrates both request channels onto one single-port backend memory bus.
- Sequences each transfer and returns a one-cycle ready pulse plus read data to the requesting pipeline stage.
- Sits between the core and the SoC memory/peripheral interconnect.

---
 rtl/core_bus_responder_pkg.sv | 19 +
 rtl/bus_rr_arbiter.sv | 26 ++
 rtl/core_bus_responder.sv | 189 ++++++++++++++++++
 tb/tb_core_bus_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_responder_pkg.sv
// Shared types for the core bus responder: FSM states, grant
// encoding and the default backend timeout.
package core_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-channel round-robin arbiter; purely combinational.
// Grant is one-hot: bit 0 = instr, bit 1 = data.
module bus_rr_arbiter
  import core_bus_responder_pkg::*;
(
  input  logic       i_req_instr,
  input  logic       i_req_data,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (1'b1)
      (i_req_instr && i_req_data):
        o_grant = (i_last_grant == GRANT_DATA) ? 2'b01 : 2'b10;
      (i_req_instr && !i_req_data):
        o_grant = 2'b01;
      (!i_req_instr && i_req_data):
        o_grant = 2'b10;
      default:
        o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/core_bus_responder.sv
// Core-side target for fetch and load/store requests on one backend bus.
// Optional BUS_TIMEOUT_EN aborts stalled transfers and adds bus_fault_out.
module core_bus_responder
  import core_bus_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] instr_address_in,
  input  logic                  instr_read_in,
  output logic [31:0]           instr_read_value_out,
  output logic                  instr_ready_out,
  input  logic [ADDR_WIDTH-1:0] data_address_in,
  input  logic                  data_read_in,
  input  logic                  data_write_in,
  input  logic [3:0]            data_write_mask_in,
  input  logic [31:0]           data_write_value_in,
  output logic [31:0]           data_read_value_out,
  output logic                  data_ready_out,
`ifdef BUS_TIMEOUT_EN
  output logic                  bus_fault_out,
`endif
  output logic [ADDR_WIDTH-1:0] mem_address_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [3:0]            mem_write_mask_out,
  output logic [31:0]           mem_write_value_out,
  input  logic [31:0]           mem_read_value_in,
  input  logic                  mem_ready_in
);

  state_e                r_state, w_state_nxt;
  grant_e                r_last, w_last_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                  r_rd, w_rd_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [3:0]            r_mask, w_mask_nxt;
  logic [31:0]           r_wval, w_wval_nxt;
  logic [31:0]           r_ival, w_ival_nxt;
  logic [31:0]           r_dval, w_dval_nxt;
  logic                  r_irdy, w_irdy_nxt;
  logic                  r_drdy, w_drdy_nxt;
  logic [1:0]            w_grant;
  logic                  w_req_data;
  logic                  w_abort;

  assign w_req_data = data_read_in | data_write_in;

  bus_rr_arbiter u_arb (
    .i_req_instr  (instr_read_in),
    .i_req_data   (w_req_data),
    .i_last_grant (r_last),
    .o_grant      (w_grant)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_fault, w_fault_nxt;

  assign bus_fault_out = r_fault;
  assign w_abort = (r_state inside {ST_INSTR, ST_DATA}) &&
                   !mem_ready_in &&
                   (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_abort      = 1'b0;
`endif

  assign mem_address_out      = r_addr;
  assign mem_read_out         = r_rd;
  assign mem_write_out        = r_wr;
  assign mem_write_mask_out   = r_mask;
  assign mem_write_value_out  = r_wval;
  assign instr_read_value_out = r_ival;
  assign instr_ready_out      = r_irdy;
  assign data_read_value_out  = r_dval;
  assign data_ready_out       = r_drdy;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_addr_nxt  = r_addr;
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_mask_nxt  = r_mask;
    w_wval_nxt  = r_wval;
    w_ival_nxt  = r_ival;
    w_dval_nxt  = r_dval;
    w_irdy_nxt  = 1'b0;
    w_drdy_nxt  = 1'b0;
`ifdef BUS_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
`ifdef BUS_TIMEOUT_EN
        w_cnt_nxt = '0;
`endif
        unique case (1'b1)
          w_grant[0]: begin
            w_state_nxt = ST_INSTR;
            w_addr_nxt  = instr_address_in;
            w_rd_nxt    = 1'b1;
            w_wr_nxt    = 1'b0;
            w_mask_nxt  = 4'b0000;
            w_wval_nxt  = 32'h0;
          end
          w_grant[1]: begin
            w_state_nxt = ST_DATA;
            w_addr_nxt  = data_address_in;
            w_rd_nxt    = data_read_in;
            w_wr_nxt    = data_write_in;
            w_mask_nxt  = data_write_mask_in;
            w_wval_nxt  = data_write_value_in;
          end
          default: ;
        endcase
      end
      ST_INSTR, ST_DATA: begin
        if (mem_ready_in || w_abort) begin
          w_state_nxt = ST_DONE;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          if (r_state == ST_INSTR) begin
            w_last_nxt = GRANT_INSTR;
            w_irdy_nxt = 1'b1;
            w_ival_nxt = w_abort ? 32'h0 : mem_read_value_in;
          end else begin
            w_last_nxt = GRANT_DATA;
            w_drdy_nxt = 1'b1;
            // stores and aborted loads return zero
            w_dval_nxt = (w_abort || r_wr) ? 32'h0 : mem_read_value_in;
          end
`ifdef BUS_TIMEOUT_EN
          w_fault_nxt = w_abort;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= GRANT_INSTR;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_mask  <= 4'b0000;
      r_wval  <= 32'h0;
      r_ival  <= 32'h0;
      r_dval  <= 32'h0;
      r_irdy  <= 1'b0;
      r_drdy  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_cnt   <= '0;
      r_fault <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_addr  <= w_addr_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_mask  <= w_mask_nxt;
      r_wval  <= w_wval_nxt;
      r_ival  <= w_ival_nxt;
      r_dval  <= w_dval_nxt;
      r_irdy  <= w_irdy_nxt;
      r_drdy  <= w_drdy_nxt;
`ifdef BUS_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_core_bus_responder.sv
// Directed bench for core_bus_responder with a transaction-level
// reference model that also plays the backend memory.
module tb_core_bus_responder;

  localparam int AW = 32;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 8;
  logic bus_fault_out;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] instr_address_in = '0;
  logic          instr_read_in = 1'b0;
  logic [31:0]   instr_read_value_out;
  logic          instr_ready_out;
  logic [AW-1:0] data_address_in = '0;
  logic          data_read_in = 1'b0;
  logic          data_write_in = 1'b0;
  logic [3:0]    data_write_mask_in = '0;
  logic [31:0]   data_write_value_in = '0;
  logic [31:0]   data_read_value_out;
  logic          data_ready_out;
  logic [AW-1:0] mem_address_out;
  logic          mem_read_out;
  logic          mem_write_out;
  logic [3:0]    mem_write_mask_out;
  logic [31:0]   mem_write_value_out;
  logic [31:0]   mem_read_value_in = '0;
  logic          mem_ready_in = 1'b0;

  always #5 clk = ~clk;

  core_bus_responder #(
    .ADDR_WIDTH (AW)
`ifdef BUS_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
`ifdef BUS_TIMEOUT_EN
    .bus_fault_out        (bus_fault_out),
`endif
    .mem_address_out      (mem_address_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_write_mask_out   (mem_write_mask_out),
    .mem_write_value_out  (mem_write_value_out),
    .mem_read_value_in    (mem_read_value_in),
    .mem_ready_in         (mem_ready_in)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'h5A5A_0000);
  endfunction

  // model: one transfer record plus edge counter
  int          cyc = 0;
  int          free_at = 0;
  int          iwait = 0;
  int          dwait = 0;
  bit          act_t = 0;
  bit          last_data = 0;
  bit          t_data, t_wr, t_abort, dq, e_str, e_rdy;
  logic [31:0] t_addr, t_wval, t_val;
  logic [3:0]  t_mask;
  int          t_g, t_w;

  // observations of the DUT for the literal checks
  int          obs_irdy = -1;
  int          obs_drdy = -1;
  int          run = 0;
  int          last_run = 0;
  int          ipulses = 0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wval = '0;
  logic [3:0]  s_mask = '0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    dq = data_read_in || data_write_in;
    if (reset) begin
      act_t = 0;
      last_data = 0;
      free_at = cyc + 1;
      run = 0;
    end else if (!act_t && cyc >= free_at && (instr_read_in || dq)) begin
      t_data = dq && (!instr_read_in || !last_data);
      act_t = 1;
      t_g = cyc;
      if (t_data) begin
        t_addr = data_address_in;
        t_wr   = data_write_in;
        t_mask = data_write_mask_in;
        t_wval = data_write_value_in;
        t_w    = dwait;
      end else begin
        t_addr = instr_address_in;
        t_wr   = 0;
        t_mask = 0;
        t_wval = 0;
        t_w    = iwait;
      end
      t_abort = 0;
`ifdef BUS_TIMEOUT_EN
      if (t_w >= TMO) begin
        t_w = TMO - 1;
        t_abort = 1;
      end
`endif
      t_val = (t_abort || t_wr) ? 32'h0 : rd_word(t_addr);
    end
    e_str = act_t && (cyc <= t_g + t_w);
    e_rdy = act_t && (cyc == t_g + t_w + 1);
    chk("mem_read", mem_read_out, e_str && !t_wr);
    chk("mem_write", mem_write_out, e_str && t_wr);
    chk("instr_ready", instr_ready_out, e_rdy && !t_data);
    chk("data_ready", data_ready_out, e_rdy && t_data);
    if (e_str) begin
      chk("mem_addr", mem_address_out, t_addr);
      if (t_wr) begin
        chk("mem_mask", mem_write_mask_out, t_mask);
        chk("mem_wval", mem_write_value_out, t_wval);
      end
    end
    if (e_rdy)
      chk(t_data ? "data_value" : "instr_value",
          t_data ? data_read_value_out : instr_read_value_out, t_val);
`ifdef BUS_TIMEOUT_EN
    chk("bus_fault", bus_fault_out, e_rdy && t_abort);
`endif
    if (mem_read_out || mem_write_out) begin
      run++;
      s_addr = mem_address_out;
      s_mask = mem_write_mask_out;
      s_wval = mem_write_value_out;
    end
    if (instr_ready_out) begin
      obs_irdy = cyc;
      ipulses++;
      last_run = run;
      run = 0;
    end
    if (data_ready_out) begin
      obs_drdy = cyc;
      last_run = run;
      run = 0;
    end
    if (e_rdy) begin
      act_t = 0;
      free_at = cyc + 2;
      last_data = t_data;
    end
    // backend: answer on schedule, noise on mem_ready when idle
    if (act_t && cyc <= t_g + t_w) begin
      mem_ready_in = (cyc == t_g + t_w) && !t_abort;
      mem_read_value_in = mem_ready_in ? rd_word(t_addr) : $urandom;
    end else begin
      mem_ready_in = (cyc % 2 == 1);
      mem_read_value_in = $urandom;
    end
  end

  task automatic wait_rdy(input bit data, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (data ? data_ready_out : instr_ready_out) ok = 1;
    end
    chk(data ? "wait_data_ready" : "wait_instr_ready", 32'(ok), 32'h1);
  endtask

  int req_e, ip0, n;
  logic [3:0] ord;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", instr_ready_out, 0);
    chk("rst_mem_addr", mem_address_out, 0);
    chk("rst_mem_mask", mem_write_mask_out, 0);
    chk("rst_ival", instr_read_value_out, 0);
    chk("rst_dval", data_read_value_out, 0);
    reset = 0;
    @(negedge clk);

    // zero-wait fetch
    iwait = 0;
    instr_address_in = 32'h100;
    instr_read_in = 1;
    req_e = cyc + 1;
    wait_rdy(0, 20);
    instr_read_in = 0;
    chk("t1_latency", obs_irdy + 1 - req_e, 2);
    chk("t1_value", instr_read_value_out, 32'h13);
    chk("t1_strobe_cycles", last_run, 1);
    chk("t1_addr", s_addr, 32'h100);
    @(negedge clk);

    // both channels held: alternation starting with data
    iwait = 0;
    dwait = 1;
    instr_address_in = 32'h200;
    data_address_in = 32'h400;
    instr_read_in = 1;
    data_read_in = 1;
    n = 0;
    ord = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (instr_ready_out) begin
        ord = {ord[2:0], 1'b0};
        n++;
        chk("t3_ival", instr_read_value_out, 32'h5A5A_0200);
      end
      if (data_ready_out) begin
        ord = {ord[2:0], 1'b1};
        n++;
        chk("t3_dval", data_read_value_out, 32'h5A5A_0400);
      end
    end
    instr_read_in = 0;
    data_read_in = 0;
    chk("t3_count", n, 4);
    chk("t3_order", ord, 4'b1010);
    @(negedge clk);

    // store with three backend wait cycles
    dwait = 3;
    data_address_in = 32'h2004;
    data_write_mask_in = 4'b0011;
    data_write_value_in = 32'hDEAD_BEEF;
    data_write_in = 1;
    req_e = cyc + 1;
    wait_rdy(1, 20);
    data_write_in = 0;
    chk("t2_latency", obs_drdy + 1 - req_e, 5);
    chk("t2_strobe_cycles", last_run, 4);
    chk("t2_value", data_read_value_out, 0);
    chk("t2_addr", s_addr, 32'h2004);
    chk("t2_mask", s_mask, 4'b0011);
    chk("t2_wval", s_wval, 32'hDEAD_BEEF);
    @(negedge clk);

    // load with one wait cycle
    dwait = 1;
    data_address_in = 32'h3000;
    data_read_in = 1;
    req_e = cyc + 1;
    wait_rdy(1, 20);
    data_read_in = 0;
    chk("ld_latency", obs_drdy + 1 - req_e, 3);
    chk("ld_value", data_read_value_out, 32'h5A5A_3000);
    @(negedge clk);

    // fetch dropped after grant; data request waits for IDLE
    iwait = 2;
    dwait = 0;
    ip0 = ipulses;
    instr_address_in = 32'h500;
    instr_read_in = 1;
    @(negedge clk);
    instr_read_in = 0;
    data_address_in = 32'h600;
    data_read_in = 1;
    wait_rdy(0, 20);
    wait_rdy(1, 20);
    data_read_in = 0;
    repeat (3) @(negedge clk);
    chk("t4_pulses", ipulses - ip0, 1);
    chk("t4_spacing", obs_drdy - obs_irdy, 3);

    // reset while a fetch is stalled
    iwait = 10;
    instr_address_in = 32'h700;
    instr_read_in = 1;
    repeat (2) @(negedge clk);
    chk("t5_busy", mem_read_out, 1);
    reset = 1;
    @(negedge clk);
    chk("t5_rd", mem_read_out, 0);
    chk("t5_wr", mem_write_out, 0);
    chk("t5_irdy", instr_ready_out, 0);
    chk("t5_drdy", data_ready_out, 0);
    chk("t5_ival", instr_read_value_out, 0);
    reset = 0;
    instr_read_in = 0;
    @(negedge clk);
    iwait = 1;
    instr_address_in = 32'h704;
    instr_read_in = 1;
    req_e = cyc + 1;
    wait_rdy(0, 20);
    instr_read_in = 0;
    chk("t5_latency", obs_irdy + 1 - req_e, 3);
    chk("t5_value", instr_read_value_out, 32'h5A5A_0704);
    @(negedge clk);

`ifdef BUS_TIMEOUT_EN
    dwait = 100;
    data_address_in = 32'h800;
    data_write_mask_in = 4'hF;
    data_write_value_in = 32'h1234;
    data_write_in = 1;
    wait_rdy(1, 30);
    data_write_in = 0;
    chk("tmo_fault", bus_fault_out, 1);
    chk("tmo_value", data_read_value_out, 0);
    chk("tmo_strobe_cycles", last_run, TMO);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
